time_of_day_hms: RTL and testbench

- Time-of-day counter sitting directly upstream of the date group (day/month/year counters).
- Divides the system clock to a 1 Hz tick and counts seconds, minutes and hours in 24-hour format.
- Emits a one-cycle end-of-day pulse on the 23:59:59 -> 00:00:00 rollover; this pulse drives the day counter's auto-increment input.
- Supports manual hour/minute edit and seconds clear for clock setting.

---
 rtl/time_of_day_hms.sv | 124 ++++++++++++
 tb/tb_time_of_day_hms.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_hms.sv
// 24-hour time-of-day counter: 1 Hz prescaler, sec/min/hour fields, manual edit,
// and a registered end-of-day pulse feeding the date group.

module time_of_day_hms_field #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic [W-1:0] cur,
  input  logic         man,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] nxt,
  output logic         wrap
);
  localparam logic [W-1:0] TOP = W'(MAX);

  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    if (man) begin
      // Manual edits wrap inside the field and never carry to the next one.
      if (clr)
        nxt = '0;
      else if (inc && !dec)
        nxt = (cur >= TOP) ? '0 : cur + 1'b1;
      else if (dec && !inc)
        nxt = (cur == '0) ? TOP : (cur > TOP) ? '0 : cur - 1'b1;
    end else if (adv) begin
      nxt  = (cur >= TOP) ? '0 : cur + 1'b1;
      wrap = (cur == TOP);
    end
  end
endmodule

module time_of_day_hms #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       inc_h,
  input  logic       dec_h,
  input  logic       inc_m,
  input  logic       dec_m,
  input  logic       clr_s,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       tick_1hz,
  output logic       eod_pulse
);
  localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] pre_q, pre_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             eod_q, eod_d;
  logic             tick, edit, adv;
  logic             sec_wrap, min_wrap, hour_wrap;

  always_comb begin
    tick   = run_en && (pre_q == PRE_MAX);
    pre_d  = pre_q;
    if (run_en)
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    edit   = inc_h | dec_h | inc_m | dec_m | clr_s;
    adv    = !edit && (tick || pend_q);
    pend_d = pend_q;
    // A tick lost to an edit waits in pend; a second one coinciding with a
    // pending advance keeps pend set so neither second is dropped.
    if (edit)
      pend_d = pend_q | tick;
    else if (adv)
      pend_d = tick & pend_q;
    tick_d = adv;
    eod_d  = adv & hour_wrap;
  end

  time_of_day_hms_field #(.W(6), .MAX(59)) u_sec (
    .cur(sec_q), .man(edit), .inc(1'b0), .dec(1'b0), .clr(clr_s),
    .adv(adv), .nxt(sec_d), .wrap(sec_wrap)
  );

  time_of_day_hms_field #(.W(6), .MAX(59)) u_min (
    .cur(min_q), .man(edit), .inc(inc_m), .dec(dec_m), .clr(1'b0),
    .adv(sec_wrap), .nxt(min_d), .wrap(min_wrap)
  );

  time_of_day_hms_field #(.W(5), .MAX(23)) u_hour (
    .cur(hour_q), .man(edit), .inc(inc_h), .dec(dec_h), .clr(1'b0),
    .adv(min_wrap), .nxt(hour_d), .wrap(hour_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      eod_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      eod_q  <= eod_d;
    end
  end

  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign tick_1hz  = tick_q;
  assign eod_pulse = eod_q;
endmodule

// File: tb/tb_time_of_day_hms.sv
// Bench for time_of_day_hms: directed scenarios plus random edits against a
// seconds-of-day reference model.

module tb_time_of_day_hms;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0, inc_h = 1'b0, dec_h = 1'b0, inc_m = 1'b0, dec_m = 1'b0, clr_s = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       tick_1hz, eod_pulse;

  int nvec = 0;
  int nerr = 0;

  // Reference state: time as seconds since midnight.
  int   m_t = 0, m_p = 0;
  logic m_pend = 1'b0, m_tick = 1'b0, m_eod = 1'b0;

  time_of_day_hms #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .inc_h(inc_h), .dec_h(dec_h), .inc_m(inc_m), .dec_m(dec_m), .clr_s(clr_s),
    .sec(sec), .min(min), .hour(hour), .tick_1hz(tick_1hz), .eod_pulse(eod_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_t = 0; m_p = 0; m_pend = 1'b0; m_tick = 1'b0; m_eod = 1'b0;
  endtask

  task automatic step(input logic re, input logic ih, input logic dh,
                      input logic im, input logic dm, input logic cs);
    int h, m, s;
    logic tk, ed;
    run_en = re; inc_h = ih; dec_h = dh; inc_m = im; dec_m = dm; clr_s = cs;
    @(posedge clk);
    tk = re && (m_p == DIV - 1);
    if (re) m_p = (m_p + 1) % DIV;
    ed = ih | dh | im | dm | cs;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    m_tick = 1'b0; m_eod = 1'b0;
    if (ed) begin
      if (ih && !dh) h = (h + 1) % 24;
      if (dh && !ih) h = (h + 23) % 24;
      if (im && !dm) m = (m + 1) % 60;
      if (dm && !im) m = (m + 59) % 60;
      if (cs) s = 0;
      m_t = h * 3600 + m * 60 + s;
      if (tk) m_pend = 1'b1;
    end else if (tk || m_pend) begin
      m_t    = (m_t + 1) % 86400;
      m_tick = 1'b1;
      m_eod  = (m_t == 0);
      m_pend = tk && m_pend;
    end
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400 && (m_t % 60) != s; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30 && (m_t / 3600) != h; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 70 && ((m_t / 60) % 60) != m; i++) step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    int ticks = 0, eods = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    nvec++;
    if ({hour, min, sec, tick_1hz, eod_pulse} !== 19'd0) begin
      nerr++; $display("FAIL reset_state: got %0d:%0d:%0d t%0b e%0b want 0:0:0 t0 e0", hour, min, sec, tick_1hz, eod_pulse);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 0, 0);
      ticks += int'(tick_1hz); eods += int'(eod_pulse);
      nvec++;
      if (hour !== 5'(m_t / 3600) || min !== 6'((m_t / 60) % 60) || sec !== 6'(m_t % 60) || tick_1hz !== m_tick || eod_pulse !== m_eod) begin
        nerr++; $display("FAIL first_count c%0d: got %0d:%0d:%0d t%0b e%0b want %0d:%0d:%0d t%0b e%0b", i, hour, min, sec, tick_1hz, eod_pulse, m_t / 3600, (m_t / 60) % 60, m_t % 60, m_tick, m_eod);
      end
    end
    nvec++;
    if (sec !== 6'd3 || ticks != 3 || eods != 0) begin
      nerr++; $display("FAIL first_count_total: got sec %0d ticks %0d eods %0d want 3 3 0", sec, ticks, eods);
    end
  endtask

  task automatic test_eod();
    int eods = 0;
    set_time(23, 59, 58);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (eod_pulse) begin
        eods++;
        nvec++;
        if (tick_1hz !== 1'b1 || {hour, min, sec} !== 17'd0) begin
          nerr++; $display("FAIL eod_shape: got %0d:%0d:%0d t%0b want 0:0:0 t1", hour, min, sec, tick_1hz);
        end
      end
      nvec++;
      if (hour !== 5'(m_t / 3600) || min !== 6'((m_t / 60) % 60) || sec !== 6'(m_t % 60) || tick_1hz !== m_tick || eod_pulse !== m_eod) begin
        nerr++; $display("FAIL eod_roll c%0d: got %0d:%0d:%0d t%0b e%0b want %0d:%0d:%0d t%0b e%0b", i, hour, min, sec, tick_1hz, eod_pulse, m_t / 3600, (m_t / 60) % 60, m_t % 60, m_tick, m_eod);
      end
    end
    nvec++;
    if (eods != 1) begin
      nerr++; $display("FAIL eod_count: got %0d want 1", eods);
    end
  endtask

  task automatic test_hour_carry();
    int m0;
    set_time(12, 59, 59);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    nvec++;
    if (hour !== 5'd13 || min !== 6'd0 || sec !== 6'd0 || eod_pulse !== 1'b0) begin
      nerr++; $display("FAIL hour_carry: got %0d:%0d:%0d e%0b want 13:0:0 e0", hour, min, sec, eod_pulse);
    end
    m0 = int'(min);
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, 1, 0, 0);
      nvec++;
      if (hour !== 5'd13 || min !== 6'((m0 + i + 1) % 60) || tick_1hz !== 1'b0 || eod_pulse !== 1'b0) begin
        nerr++; $display("FAIL inc_m_wrap c%0d: got %0d:%0d t%0b e%0b want 13:%0d t0 e0", i, hour, min, tick_1hz, eod_pulse, (m0 + i + 1) % 60);
      end
    end
  endtask

  task automatic test_collision();
    set_time(10, 20, 30);
    for (int i = 0; i < DIV && m_p != DIV - 1; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    nvec++;
    if (hour !== 5'd10 || min !== 6'd21 || sec !== 6'd30 || tick_1hz !== 1'b0) begin
      nerr++; $display("FAIL collide_edit: got %0d:%0d:%0d t%0b want 10:21:30 t0", hour, min, sec, tick_1hz);
    end
    step(0, 0, 0, 0, 0, 0);
    nvec++;
    if (hour !== 5'd10 || min !== 6'd21 || sec !== 6'd31 || tick_1hz !== 1'b1 || eod_pulse !== 1'b0) begin
      nerr++; $display("FAIL collide_pending: got %0d:%0d:%0d t%0b e%0b want 10:21:31 t1 e0", hour, min, sec, tick_1hz, eod_pulse);
    end
  endtask

  task automatic test_freeze_edit();
    set_time(5, 6, 7);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0);
      nvec++;
      if (hour !== 5'd5 || min !== 6'd6 || sec !== 6'd7 || tick_1hz !== 1'b0 || eod_pulse !== 1'b0) begin
        nerr++; $display("FAIL freeze c%0d: got %0d:%0d:%0d t%0b e%0b want 5:6:7 t0 e0", i, hour, min, sec, tick_1hz, eod_pulse);
      end
    end
    step(0, 1, 1, 0, 0, 0);
    nvec++;
    if (hour !== 5'd5) begin
      nerr++; $display("FAIL inc_dec_h: got %0d want 5", hour);
    end
    for (int i = 0; i < 30 && m_t / 3600 != 0; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    nvec++;
    if (hour !== 5'd23 || min !== 6'd6) begin
      nerr++; $display("FAIL dec_h_wrap: got %0d:%0d want 23:6", hour, min);
    end
    step(0, 0, 0, 0, 0, 1);
    nvec++;
    if (sec !== 6'd0 || hour !== 5'd23 || tick_1hz !== 1'b0) begin
      nerr++; $display("FAIL clr_s: got %0d:%0d t%0b want 23:0 t0", hour, sec, tick_1hz);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, i < 12, 0, 0);
      nvec++;
      if (hour !== 5'(m_t / 3600) || min !== 6'((m_t / 60) % 60) || sec !== 6'(m_t % 60) || tick_1hz !== m_tick || eod_pulse !== m_eod) begin
        nerr++; $display("FAIL back_to_back c%0d: got %0d:%0d:%0d t%0b e%0b want %0d:%0d:%0d t%0b e%0b", i, hour, min, sec, tick_1hz, eod_pulse, m_t / 3600, (m_t / 60) % 60, m_t % 60, m_tick, m_eod);
      end
    end
  endtask

  task automatic test_async_reset();
    int first = -1;
    set_time(23, 59, 59);
    for (int i = 0; i < DIV && m_p != 2; i++) step(1, 0, 0, 0, 0, 0);
    run_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    nvec++;
    if ({hour, min, sec, tick_1hz, eod_pulse} !== 19'd0) begin
      nerr++; $display("FAIL async_reset: got %0d:%0d:%0d t%0b e%0b want 0:0:0 t0 e0", hour, min, sec, tick_1hz, eod_pulse);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (tick_1hz && first < 0) first = i;
      nvec++;
      if (hour !== 5'(m_t / 3600) || min !== 6'((m_t / 60) % 60) || sec !== 6'(m_t % 60) || tick_1hz !== m_tick || eod_pulse !== m_eod) begin
        nerr++; $display("FAIL post_reset c%0d: got %0d:%0d:%0d t%0b e%0b want %0d:%0d:%0d t%0b e%0b", i, hour, min, sec, tick_1hz, eod_pulse, m_t / 3600, (m_t / 60) % 60, m_t % 60, m_tick, m_eod);
      end
    end
    nvec++;
    if (first != DIV) begin
      nerr++; $display("FAIL post_reset_latency: got %0d want %0d", first, DIV);
    end
  endtask

  task automatic test_random();
    logic re, ih, dh, im, dm, cs;
    for (int i = 0; i < 600; i++) begin
      re = ($urandom_range(0, 7) != 0);
      ih = ($urandom_range(0, 11) == 0);
      dh = ($urandom_range(0, 11) == 0);
      im = ($urandom_range(0, 9) == 0);
      dm = ($urandom_range(0, 9) == 0);
      cs = ($urandom_range(0, 19) == 0);
      step(re, ih, dh, im, dm, cs);
      nvec++;
      if (hour !== 5'(m_t / 3600) || min !== 6'((m_t / 60) % 60) || sec !== 6'(m_t % 60) || tick_1hz !== m_tick || eod_pulse !== m_eod) begin
        nerr++; $display("FAIL random c%0d: got %0d:%0d:%0d t%0b e%0b want %0d:%0d:%0d t%0b e%0b", i, hour, min, sec, tick_1hz, eod_pulse, m_t / 3600, (m_t / 60) % 60, m_t % 60, m_tick, m_eod);
      end
    end
  endtask

  initial begin
    test_reset();
    test_eod();
    test_hour_carry();
    test_collision();
    test_freeze_edit();
    test_back_to_back();
    test_async_reset();
    set_time(23, 59, 50);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
